// File: rtl/servo_pulse_decoder.sv
// servo_pulse_decoder: measures the high time of an incoming 50Hz servo/RC pulse
// train and turns it into a position code on the 1.0ms-2.0ms scale. Malformed pulses
// and loss of signal are also flagged.
//
// Ports
//   clk             system clock
//   rst             synchronous, active-low reset (rst==0 resets)
//   servo_in        asynchronous pulse input from the receiver pin
//   position        last accepted position code (registered, holds between strobes)
//   position_valid  one-cycle strobe when position updates
//   pulse_error     one-cycle strobe when a pulse is rejected (too short or too long)
//   signal_lost     level, high when no valid frame has been seen recently
module servo_pulse_decoder #(
  parameter int unsigned CLK_FREQUENCY     = 50000000,
  parameter int unsigned CTR_LEN           = 21,
  parameter int unsigned POSITION_DATA_LEN = 8,
  parameter int unsigned MIN_PULSE_CYCLES  = 50000,
  parameter int unsigned STEP_CYCLES       = 195,
  parameter int unsigned MIN_ACCEPT_CYCLES = 40000,
  parameter int unsigned MAX_ACCEPT_CYCLES = 110000,
  parameter int unsigned TIMEOUT_CYCLES    = 1250000,
  parameter int unsigned SYNC_STAGES       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         servo_in,
  output logic [POSITION_DATA_LEN-1:0] position,
  output logic                         position_valid,
  output logic                         pulse_error,
  output logic                         signal_lost
);

  localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned STEP_W = $clog2(STEP_CYCLES + 1);
  localparam logic [POSITION_DATA_LEN-1:0] POS_MID  = {1'b1, {(POSITION_DATA_LEN-1){1'b0}}};
  localparam logic [POSITION_DATA_LEN-1:0] POS_MAX  = {POSITION_DATA_LEN{1'b1}};
  localparam logic [CTR_LEN-1:0]           MIN_PLS  = CTR_LEN'(MIN_PULSE_CYCLES);
  localparam logic [CTR_LEN-1:0]           MIN_ACC  = CTR_LEN'(MIN_ACCEPT_CYCLES);
  localparam logic [CTR_LEN-1:0]           MAX_ACC  = CTR_LEN'(MAX_ACCEPT_CYCLES);
  localparam logic [CTR_LEN-1:0]           TMO      = CTR_LEN'(TIMEOUT_CYCLES);
  localparam logic [CTR_LEN-1:0]           TMO_M1   = CTR_LEN'(TIMEOUT_CYCLES - 1);
  localparam logic [STEP_W-1:0]            STEP_TOP = STEP_W'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    ARM,
    IDLE,
    HIGH,
    WAIT_LOW
  } state_t;

  // Clock rate is informational only; the cycle-count parameters already encode it.
  logic unused_clk_frequency;
  assign unused_clk_frequency = ^CLK_FREQUENCY;

  // Input synchroniser plus history flop. Not reset, so the ARM state sees the true
  // pin level straight out of reset and can skip a pulse already in progress.
  logic [SYNC_N-1:0] sync_q;
  logic              s_d;

  always_ff @(posedge clk) begin
    sync_q <= {sync_q[SYNC_N-2:0], servo_in};
    s_d    <= sync_q[SYNC_N-1];
  end

  logic s, rise, fall;
  assign s    = sync_q[SYNC_N-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  state_t                       state_q, state_d;
  logic [CTR_LEN-1:0]           width_q, width_d;
  logic [STEP_W-1:0]            step_q, step_d;
  logic [POSITION_DATA_LEN-1:0] code_q, code_d;
  logic [CTR_LEN-1:0]           period_q, period_d;
  logic [POSITION_DATA_LEN-1:0] position_d;
  logic                         valid_d, error_d, lost_d;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ARM;
      width_q        <= '0;
      step_q         <= '0;
      code_q         <= '0;
      period_q       <= '0;
      position       <= POS_MID;
      position_valid <= 1'b0;
      pulse_error    <= 1'b0;
      signal_lost    <= 1'b1;
    end else begin
      state_q        <= state_d;
      width_q        <= width_d;
      step_q         <= step_d;
      code_q         <= code_d;
      period_q       <= period_d;
      position       <= position_d;
      position_valid <= valid_d;
      pulse_error    <= error_d;
      signal_lost    <= lost_d;
    end
  end

  // Next-state, width measurement, incremental code build and strobes.
  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    step_d     = step_q;
    code_d     = code_q;
    position_d = position;
    valid_d    = 1'b0;
    error_d    = 1'b0;

    case (state_q)
      ARM: begin
        if (!s) state_d = IDLE;
      end

      IDLE: begin
        // The rise cycle is the first high cycle, so the count starts at one.
        if (rise) begin
          width_d = CTR_LEN'(1);
          step_d  = '0;
          code_d  = '0;
          state_d = HIGH;
        end
      end

      HIGH: begin
        if (fall) begin
          state_d = IDLE;
          if (width_q < MIN_ACC) begin
            error_d = 1'b1;
          end else begin
            position_d = code_q;
            valid_d    = 1'b1;
          end
        end else if (width_q == MAX_ACC) begin
          // This cycle would be high cycle MAX_ACCEPT_CYCLES+1.
          error_d = 1'b1;
          state_d = WAIT_LOW;
        end else begin
          width_d = width_q + CTR_LEN'(1);
          // Every STEP_CYCLES high cycles beyond the 1.0ms point add one code LSB.
          if (width_q >= MIN_PLS) begin
            if (step_q == STEP_TOP) begin
              step_d = '0;
              if (code_q != POS_MAX) code_d = code_q + POSITION_DATA_LEN'(1);
            end else begin
              step_d = step_q + STEP_W'(1);
            end
          end
        end
      end

      WAIT_LOW: begin
        if (!s) state_d = IDLE;
      end
    endcase
  end

  // Frame-period watchdog; a rise in the timeout cycle wins and leaves the flag alone.
  always_comb begin
    period_d = period_q;
    lost_d   = signal_lost;
    if (rise) begin
      period_d = '0;
    end else if (period_q != TMO) begin
      period_d = period_q + CTR_LEN'(1);
      if (period_q == TMO_M1) lost_d = 1'b1;
    end
    if (valid_d) lost_d = 1'b0;
  end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Testbench for servo_pulse_decoder. The decoder runs with shortened timing
// (1.0ms -> 500 cycles, 2 cycles per LSB, accept 400..1100, timeout 12500) so the
// same boundaries are reachable in a short run; code = min(255, max(0, w-500)/2).
module tb_servo_pulse_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       servo_in = 1'b0;
  logic [7:0] position;
  logic       position_valid;
  logic       pulse_error;
  logic       signal_lost;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  logic [7:0] prev_pos = 8'd128;
  logic [7:0] exp_pos = 8'd128;

  servo_pulse_decoder #(
    .CLK_FREQUENCY    (50000000),
    .CTR_LEN          (16),
    .POSITION_DATA_LEN(8),
    .MIN_PULSE_CYCLES (500),
    .STEP_CYCLES      (2),
    .MIN_ACCEPT_CYCLES(400),
    .MAX_ACCEPT_CYCLES(1100),
    .TIMEOUT_CYCLES   (12500),
    .SYNC_STAGES      (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .servo_in      (servo_in),
    .position      (position),
    .position_valid(position_valid),
    .pulse_error   (pulse_error),
    .signal_lost   (signal_lost)
  );

  always #5 clk = ~clk;

  // Strobe counters and invariants, sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      if (position_valid) valid_cnt++;
      if (pulse_error) err_cnt++;
      if (position_valid || pulse_error) begin
        checks++;
        if (position_valid && pulse_error) begin
          errors++;
          $display("FAIL strobe_overlap: valid=%0b error=%0b, required not both high", position_valid, pulse_error);
        end
      end
      if (position !== prev_pos) begin
        checks++;
        if (position_valid !== 1'b1) begin
          errors++;
          $display("FAIL position_change: position %0d -> %0d without position_valid", prev_pos, position);
        end
      end
    end
    prev_pos = position;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives a w-cycle high pulse then lo low cycles; starts and ends at a falling edge.
  task automatic pulse(input int w, input int lo);
    servo_in = 1'b1;
    repeat (w) @(posedge clk);
    @(negedge clk);
    servo_in = 1'b0;
    repeat (lo) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (position !== 8'd128) begin errors++; $display("FAIL reset_position: got %0d want 128", position); end
    checks++; if (position_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", position_valid); end
    checks++; if (pulse_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %0b want 0", pulse_error); end
    checks++; if (signal_lost !== 1'b1) begin errors++; $display("FAIL reset_lost: got %0b want 1", signal_lost); end
    rst = 1'b1;
  endtask

  task automatic test_first_frame();
    int v0;
    v0 = valid_cnt;
    servo_in = 1'b1;
    repeat (756) @(posedge clk);
    @(negedge clk);
    servo_in = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (position_valid !== 1'b0) begin errors++; $display("FAIL latency_e0: valid=%0b want 0", position_valid); end
    checks++; if (signal_lost !== 1'b1) begin errors++; $display("FAIL lost_before_strobe: got %0b want 1", signal_lost); end
    @(posedge clk); @(negedge clk);
    checks++; if (position_valid !== 1'b0) begin errors++; $display("FAIL latency_e1: valid=%0b want 0", position_valid); end
    @(posedge clk); @(negedge clk);
    checks++; if (position_valid !== 1'b1) begin errors++; $display("FAIL latency_e2: valid=%0b want 1", position_valid); end
    checks++; if (position !== 8'd128) begin errors++; $display("FAIL first_position: got %0d want 128", position); end
    checks++; if (signal_lost !== 1'b0) begin errors++; $display("FAIL lost_clears_with_strobe: got %0b want 0", signal_lost); end
    @(posedge clk); @(negedge clk);
    checks++; if (position_valid !== 1'b0) begin errors++; $display("FAIL strobe_width: valid=%0b want 0", position_valid); end
    repeat (1240) @(posedge clk);
    @(negedge clk);
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL first_frame_count: got %0d want %0d", valid_cnt, v0 + 1); end
    exp_pos = 8'd128;
  endtask

  task automatic test_frames();
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 3; i++) begin
      pulse(756, 1244);
      checks++; if (position !== 8'd128) begin errors++; $display("FAIL frame_position[%0d]: got %0d want 128", i, position); end
      checks++; if (valid_cnt !== v0 + i + 1) begin errors++; $display("FAIL frame_valid_count[%0d]: got %0d want %0d", i, valid_cnt, v0 + i + 1); end
    end
    checks++; if (err_cnt !== e0) begin errors++; $display("FAIL frame_errors: got %0d want %0d", err_cnt, e0); end
  endtask

  task automatic test_widths();
    int ws[10] = '{500, 600, 1000, 450, 400, 1100, 1009, 1010, 502, 501};
    int cs[10] = '{0, 50, 250, 0, 0, 255, 254, 255, 1, 0};
    int v0, e0;
    for (int i = 0; i < 10; i++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      pulse(ws[i], 300);
      checks++; if (position !== 8'(cs[i])) begin errors++; $display("FAIL width_code w=%0d: got %0d want %0d", ws[i], position, cs[i]); end
      checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL width_valid w=%0d: got %0d strobes want 1", ws[i], valid_cnt - v0); end
      checks++; if (err_cnt !== e0) begin errors++; $display("FAIL width_error w=%0d: got %0d error strobes want 0", ws[i], err_cnt - e0); end
    end
    exp_pos = 8'd0;
  endtask

  task automatic test_short();
    int ws[2] = '{250, 399};
    int v0, e0;
    for (int i = 0; i < 2; i++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      pulse(ws[i], 300);
      checks++; if (err_cnt !== e0 + 1) begin errors++; $display("FAIL short_error w=%0d: got %0d error strobes want 1", ws[i], err_cnt - e0); end
      checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL short_valid w=%0d: got %0d strobes want 0", ws[i], valid_cnt - v0); end
      checks++; if (position !== exp_pos) begin errors++; $display("FAIL short_position w=%0d: got %0d want %0d", ws[i], position, exp_pos); end
    end
  endtask

  task automatic test_long();
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    servo_in = 1'b1;
    for (int e = 1; e <= 1500; e++) begin
      @(posedge clk); @(negedge clk);
      if (e == 1102) begin
        checks++; if (pulse_error !== 1'b0) begin errors++; $display("FAIL long_early: error=%0b at count 1100, want 0", pulse_error); end
      end
      if (e == 1103) begin
        checks++; if (pulse_error !== 1'b1) begin errors++; $display("FAIL long_error: error=%0b at count 1101, want 1", pulse_error); end
      end
      if (e == 1104) begin
        checks++; if (pulse_error !== 1'b0) begin errors++; $display("FAIL long_width: error=%0b one cycle later, want 0", pulse_error); end
      end
    end
    servo_in = 1'b0;
    repeat (300) @(posedge clk);
    @(negedge clk);
    checks++; if (err_cnt !== e0 + 1) begin errors++; $display("FAIL long_error_count: got %0d want 1", err_cnt - e0); end
    checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL long_valid: got %0d strobes want 0", valid_cnt - v0); end
    checks++; if (position !== exp_pos) begin errors++; $display("FAIL long_position: got %0d want %0d", position, exp_pos); end
    pulse(756, 300);
    checks++; if (position !== 8'd128) begin errors++; $display("FAIL after_long_position: got %0d want 128", position); end
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL after_long_valid: got %0d strobes want 1", valid_cnt - v0); end
    exp_pos = 8'd128;
  endtask

  task automatic test_timeout();
    servo_in = 1'b1;
    for (int e = 1; e <= 12503; e++) begin
      @(posedge clk); @(negedge clk);
      if (e == 756) servo_in = 1'b0;
      if (e == 760) begin
        checks++; if (signal_lost !== 1'b0) begin errors++; $display("FAIL timeout_cleared: got %0b want 0", signal_lost); end
      end
      if (e == 12502) begin
        checks++; if (signal_lost !== 1'b0) begin errors++; $display("FAIL timeout_early: got %0b want 0 one cycle before", signal_lost); end
      end
      if (e == 12503) begin
        checks++; if (signal_lost !== 1'b1) begin errors++; $display("FAIL timeout_set: got %0b want 1", signal_lost); end
      end
    end
    checks++; if (position !== 8'd128) begin errors++; $display("FAIL timeout_position: got %0d want 128", position); end
  endtask

  task automatic test_reset_mid_pulse();
    int v0, e0;
    pulse(1000, 300);
    checks++; if (position !== 8'd250) begin errors++; $display("FAIL pre_reset_position: got %0d want 250", position); end
    servo_in = 1'b1;
    repeat (300) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (position !== 8'd128) begin errors++; $display("FAIL midreset_position: got %0d want 128", position); end
    checks++; if (signal_lost !== 1'b1) begin errors++; $display("FAIL midreset_lost: got %0b want 1", signal_lost); end
    rst = 1'b1;
    v0 = valid_cnt;
    e0 = err_cnt;
    repeat (400) @(posedge clk);
    @(negedge clk);
    servo_in = 1'b0;
    repeat (600) @(posedge clk);
    @(negedge clk);
    checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL midreset_valid: got %0d strobes want 0", valid_cnt - v0); end
    checks++; if (err_cnt !== e0) begin errors++; $display("FAIL midreset_error: got %0d strobes want 0", err_cnt - e0); end
    checks++; if (position !== 8'd128) begin errors++; $display("FAIL midreset_hold: got %0d want 128", position); end
    checks++; if (signal_lost !== 1'b1) begin errors++; $display("FAIL midreset_lost_hold: got %0b want 1", signal_lost); end
    pulse(600, 300);
    checks++; if (position !== 8'd50) begin errors++; $display("FAIL post_reset_position: got %0d want 50", position); end
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL post_reset_valid: got %0d strobes want 1", valid_cnt - v0); end
    checks++; if (signal_lost !== 1'b0) begin errors++; $display("FAIL post_reset_lost: got %0b want 0", signal_lost); end
  endtask

  task automatic test_back_to_back();
    int ws[5] = '{1100, 756, 500, 1100, 600};
    int cs[5] = '{255, 128, 0, 255, 50};
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 5; i++) begin
      pulse(ws[i], 4);
      checks++; if (position !== 8'(cs[i])) begin errors++; $display("FAIL b2b_code[%0d] w=%0d: got %0d want %0d", i, ws[i], position, cs[i]); end
    end
    checks++; if (valid_cnt !== v0 + 5) begin errors++; $display("FAIL b2b_valid: got %0d strobes want 5", valid_cnt - v0); end
    checks++; if (err_cnt !== e0) begin errors++; $display("FAIL b2b_error: got %0d strobes want 0", err_cnt - e0); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_frames();
    test_widths();
    test_short();
    test_long();
    test_timeout();
    test_reset_mid_pulse();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
